switch_scheduler: RTL
=====================

# switch_scheduler

Central scheduler and crossbar for the 4-port packet switch. Holds one ingress packet per input port, picks among pending ports round-robin, and copies the selected packet to every egress port named in its target mask. Unicast, multicast and broadcast are handled alike: target bits are delivered one or more at a time as egress ports stop suspending, and a packet is never returned to its ingress port. The block sits between the per-port input interfaces (ip_valid/ip_suspend/ip_data) and output interfaces (op_valid/op_suspend/op_data).

## Interface
- NUM_PORTS, 4, number of switch ports; the design and test plan cover 4 only.
- DATA_W, 16, packet width; layout is {data[15:8], source[7:4], target[3:0]}.
- clk  input  1  switch clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset; one clock, one reset domain.
- ip_valid  input  [NUM_PORTS-1:0]  per-port packet strobe.
- ip_data  input  [NUM_PORTS-1:0][DATA_W-1:0]  per-port ingress packet.
- ip_suspend  output  [NUM_PORTS-1:0]  high = that port's holding buffer is full; the sender must wait.
- op_valid  output  [NUM_PORTS-1:0]  one-cycle delivery pulse per egress port.
- op_data  output  [NUM_PORTS-1:0][DATA_W-1:0]  egress packet; holds its value until the next delivery on that port.
- op_suspend  input  [NUM_PORTS-1:0]  high = egress port cannot take a packet this cycle.
- drop_err  output  1  one-cycle pulse when a granted packet has no legal destination.

## Operation
- Port i is addressed by target bit i (mask 1<<i).
- Accept: at an edge where ip_valid[i]=1 and ip_suspend[i]=0, ip_data[i] is latched into buf[i] and full[i] is set. ip_suspend[i] = full[i], registered.
- While ip_suspend[i]=1, ip_valid[i] is ignored. The packet is not captured; the sender is responsible for holding it.
- FSM states:
  - IDLE: if any full[i] is set, the round-robin arbiter grants one port, winner w.
    - Load remaining mask rem = buf[w].target & ~(1<<w).
    - If rem==0 (target 0, or self only): pulse drop_err, clear full[w], advance the pointer, stay in IDLE.
    - Otherwise go to SEND.
  - SEND: at each edge, every d with rem[d]=1 and op_suspend[d]=0 gets op_valid[d]<=1 and op_data[d]<=buf[w]; those bits are cleared from rem.
    - When the delivered set equals rem: clear full[w], advance the pointer to w+1 mod 4, return to IDLE.
- Round-robin: the search starts at ptr and wraps 3->0. ptr resets to 0 and moves only on grant completion (delivery or drop).
- op_valid defaults to 0 every cycle. Only one packet is in flight at a time, so consecutive deliveries to a port always have at least one low cycle between them.
- Packet fields are forwarded unmodified. Type (SINGLE: 1,2,4,8; BROADCAST: 15; else MULTICAST) is not needed for routing.
- Simultaneous events:
  - A port may accept a new packet in the same edge its buffer is freed only if ip_suspend was already low. It is not low, so refill starts the edge after the free.
  - Other ports keep accepting during SEND.
- Reset, at any time including mid-SEND:
  - full, rem, ptr, op_valid, op_data, drop_err and ip_suspend all cleared to 0; state = IDLE.
  - The in-flight packet and all buffered packets are discarded; partially delivered multicasts are not completed.

## Timing
- Packet accepted at edge k: ip_suspend high from k.
- Grant at edge k+1 if the arbiter is idle and the port wins.
- First op_valid at edge k+2, i.e. minimum 2-cycle latency.
- A fully ready broadcast finishes in one SEND cycle; the buffer is freed at k+2 and ip_suspend drops after k+2.
- Each suspended destination adds cycles until its op_suspend is sampled low. There is no timeout.
- Peak throughput: one packet every 2 cycles across the whole switch.

## Structure
- Package pkg_switch: NUM_PORTS; field slice constants TGT_LSB=0, SRC_LSB=4, DATA_LSB=8; state enum sched_state_t {IDLE, SEND}; packet_type_t and the target-to-type function, shared with verification.
- Sub-module rr_arbiter: 4 requests, pointer input, one-hot grant plus encoded index out. It is purely combinational; the pointer register lives in switch_scheduler.

## Test plan
- Unicast: port 0 sends 16'hA5_1_2, no suspends -> op_valid[1] pulses at k+2 with op_data[1]=16'hA512; no other op_valid; ip_suspend[0] high for edges k..k+2.
- Broadcast: port 2 sends target 4'hF -> ports 0, 1, 3 pulse together at k+2; port 2 receives nothing.
- Blocked multicast: port 1 sends target 4'b1001 with op_suspend[3] held high 5 cycles -> port 0 delivers at k+2, port 3 delivers the edge after op_suspend[3] falls, then the buffer frees.
- Fairness: all 4 ports load unicast packets in the same cycle -> grants in order 0, 1, 2, 3, then the pointer wraps; no port is granted twice before all others are served.
- Illegal targets: target 4'h0 on port 3, and target 4'b0001 on port 0 -> drop_err pulses once each, no op_valid, buffers freed.
- Reset mid-SEND: rst asserted while a multicast waits on op_suspend -> next cycle all outputs 0, state IDLE, no further deliveries of that packet.

Source files
------------

// File: rtl/switch_scheduler_pkg.sv
`default_nettype none
//============================================================================
// Module : pkg_switch
// Brief  : Shared constants, state/packet types and target classification
//          for the 4-port switch scheduler.
// Rev    : 1.0  initial release
//============================================================================
package pkg_switch;

    localparam int NUM_PORTS = 4;
    localparam int DATA_W    = 16;
    localparam int PTR_W     = $clog2(NUM_PORTS);

    localparam int TGT_LSB   = 0;
    localparam int SRC_LSB   = 4;
    localparam int DATA_LSB  = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } sched_state_t;

    typedef enum logic [1:0] {
        PKT_SINGLE    = 2'd0,
        PKT_MULTICAST = 2'd1,
        PKT_BROADCAST = 2'd2
    } packet_type_t;

    function automatic packet_type_t pkt_type(input logic [NUM_PORTS-1:0] tgt);
        case (tgt)
            4'h1, 4'h2, 4'h4, 4'h8: pkt_type = PKT_SINGLE;
            4'hF:                   pkt_type = PKT_BROADCAST;
            default:                pkt_type = PKT_MULTICAST;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/switch_scheduler_if.sv
`default_nettype none
//============================================================================
// Module : switch_scheduler_if
// Brief  : Per-port ingress/egress bundle between the port interfaces and
//          the central scheduler.
// Rev    : 1.0  initial release
//============================================================================
interface switch_scheduler_if
    import pkg_switch::*;
#(
    parameter int N_PORTS = NUM_PORTS,
    parameter int D_W     = DATA_W
);
    logic [N_PORTS-1:0]          ip_valid;
    logic [N_PORTS-1:0][D_W-1:0] ip_data;
    logic [N_PORTS-1:0]          ip_suspend;
    logic [N_PORTS-1:0]          op_valid;
    logic [N_PORTS-1:0][D_W-1:0] op_data;
    logic [N_PORTS-1:0]          op_suspend;
    logic                        drop_err;

    // Port side: offers packets and applies egress back-pressure.
    modport master (
        output ip_valid, ip_data, op_suspend,
        input  ip_suspend, op_valid, op_data, drop_err
    );

    // Scheduler side.
    modport slave (
        input  ip_valid, ip_data, op_suspend,
        output ip_suspend, op_valid, op_data, drop_err
    );
endinterface
`default_nettype wire

// File: rtl/switch_scheduler_arbiter.sv
`default_nettype none
//============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin arbiter; search starts at i_ptr and
//          wraps. Pointer state is owned by the caller.
// Rev    : 1.0  initial release
//============================================================================
module rr_arbiter
    import pkg_switch::*;
(
    input  wire logic [NUM_PORTS-1:0] i_req,
    input  wire logic [PTR_W-1:0]     i_ptr,
    output logic      [NUM_PORTS-1:0] o_grant,
    output logic      [PTR_W-1:0]     o_idx,
    output logic                      o_any
);
    logic [PTR_W-1:0] w_cand;

    // Index arithmetic wraps naturally because NUM_PORTS is a power of two.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_cand = i_ptr + PTR_W'(k);
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/switch_scheduler.sv
`default_nettype none
//============================================================================
// Module : switch_scheduler
// Brief  : One-packet-per-port holding buffers, round-robin grant and
//          crossbar copy to every egress port in the target mask.
// Rev    : 1.0  initial release
//============================================================================
module switch_scheduler
    import pkg_switch::*;
(
    input  wire logic         clk,
    input  wire logic         rst,
    switch_scheduler_if.slave bus
);
    sched_state_t                     r_state;
    logic [NUM_PORTS-1:0]             r_full;
    logic [NUM_PORTS-1:0][DATA_W-1:0] r_buf;
    logic [NUM_PORTS-1:0]             r_rem;
    logic [PTR_W-1:0]                 r_ptr;
    logic [PTR_W-1:0]                 r_win;
    logic [NUM_PORTS-1:0]             r_op_valid;
    logic [NUM_PORTS-1:0][DATA_W-1:0] r_op_data;
    logic                             r_drop_err;

    logic [NUM_PORTS-1:0]             w_grant;
    logic [PTR_W-1:0]                 w_idx;
    logic                             w_any;
    logic [NUM_PORTS-1:0]             w_rem_load;
    logic [NUM_PORTS-1:0]             w_deliver;

    rr_arbiter u_arb (
        .i_req   (r_full),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // A packet is never reflected back to its own ingress port.
    assign w_rem_load = r_buf[w_idx][TGT_LSB +: NUM_PORTS] & ~w_grant;
    assign w_deliver  = r_rem & ~bus.op_suspend;

    assign bus.ip_suspend = r_full;
    assign bus.op_valid   = r_op_valid;
    assign bus.op_data    = r_op_data;
    assign bus.drop_err   = r_drop_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_full     <= '0;
            r_buf      <= '0;
            r_rem      <= '0;
            r_ptr      <= '0;
            r_win      <= '0;
            r_op_valid <= '0;
            r_op_data  <= '0;
            r_drop_err <= 1'b0;
        end else begin
            r_op_valid <= '0;
            r_drop_err <= 1'b0;

            // A freed buffer still shows full this cycle, so accept and
            // release never target the same port on one edge.
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (bus.ip_valid[i] && !r_full[i]) begin
                    r_buf[i]  <= bus.ip_data[i];
                    r_full[i] <= 1'b1;
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_win <= w_idx;
                        if (w_rem_load == '0) begin
                            r_drop_err    <= 1'b1;
                            r_full[w_idx] <= 1'b0;
                            r_ptr         <= w_idx + PTR_W'(1);
                        end else begin
                            r_rem   <= w_rem_load;
                            r_state <= SEND;
                        end
                    end
                end
                SEND: begin
                    for (int d = 0; d < NUM_PORTS; d++) begin
                        if (w_deliver[d]) begin
                            r_op_valid[d] <= 1'b1;
                            r_op_data[d]  <= r_buf[r_win];
                        end
                    end
                    r_rem <= r_rem & ~w_deliver;
                    if (w_deliver == r_rem) begin
                        r_full[r_win] <= 1'b0;
                        r_ptr         <= r_win + PTR_W'(1);
                        r_state       <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
